// File: rtl/tqvp_prism_host_if.sv
// Host register interface between the TinyQV peripheral bus and a PRISM FSM core:
// control, masked interrupts, extra inputs and a timestamped output-capture FIFO.
module tqvp_prism_host_if #(
  parameter int EXTRA_W     = 9,
  parameter int OUT_W       = 13,
  parameter int TS_W        = 16,
  parameter int DEPTH_LOG2  = 3,
  parameter int FIFO_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         address,
  input  logic [31:0]        data_in,
  input  logic [1:0]         data_write_n,
  input  logic [1:0]         data_read_n,
  output logic [31:0]        data_out,
  output logic               data_ready,
  output logic               user_interrupt,
  output logic               prism_reset,
  output logic               prism_enable,
  output logic               prism_dbg_wr,
  input  logic [31:0]        prism_rdata,
  input  logic               prism_halt,
  input  logic               prism_cond,
  input  logic [OUT_W-1:0]   prism_out,
  output logic [EXTRA_W-1:0] extra_in
);

  localparam int ENT_W = OUT_W + TS_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THRESH_C = (DEPTH_LOG2+1)'(FIFO_THRESH);

  localparam logic [5:0] A_CTRL  = 6'h20;
  localparam logic [5:0] A_STAT  = 6'h24;
  localparam logic [5:0] A_EN    = 6'h28;
  localparam logic [5:0] A_EXTRA = 6'h2C;
  localparam logic [5:0] A_FDATA = 6'h30;
  localparam logic [5:0] A_FSTAT = 6'h34;

  logic [2:0]            ctrl;
  logic [3:0]            irq_en;
  logic [EXTRA_W-1:0]    extra;
  logic                  stat_halt, stat_cond, stat_ovf;
  logic                  halt_r, cond_r;
  logic [TS_W-1:0]       ts;
  logic [OUT_W-1:0]      out_prev;
  logic                  base_pend;
  logic                  rd_r;
  logic [ENT_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic        wr32, rd_act, is_local;
  logic        wr_ctrl, wr_stat, wr_en, wr_extra;
  logic        cap_rise, full, empty, lvl_hit;
  logic        pop_req, pop, push_req, push, ovf_set;
  logic        halt_rise, cond_rise;
  logic [3:0]  irq_stat;
  logic [31:0] fifo_word;
  logic        unused_data;

  assign wr32     = (data_write_n == 2'b10);
  assign rd_act   = (data_read_n != 2'b11);
  assign is_local = address[5];

  assign wr_ctrl  = wr32 & (address == A_CTRL);
  assign wr_stat  = wr32 & (address == A_STAT);
  assign wr_en    = wr32 & (address == A_EN);
  assign wr_extra = wr32 & (address == A_EXTRA);

  assign prism_dbg_wr = wr32 & ~is_local;
  assign data_ready   = 1'b1;
  assign prism_enable = ctrl[0];
  assign prism_reset  = ctrl[1];
  assign extra_in     = extra;
  assign unused_data  = ^data_in;

  assign cap_rise  = wr_ctrl & data_in[2] & ~ctrl[2];
  assign halt_rise = prism_halt & ~halt_r;
  assign cond_rise = prism_cond & ~cond_r;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign lvl_hit = (count >= THRESH_C);

  // Pop fires on the leading cycle of a read strobe only, so a held strobe pops once.
  assign pop_req  = rd_act & ~rd_r & (address == A_FDATA);
  assign pop      = pop_req & ~empty;
  assign push_req = ctrl[2] & ctrl[0] & (base_pend | (prism_out != out_prev));
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  assign irq_stat       = {stat_ovf, lvl_hit, stat_cond, stat_halt};
  assign user_interrupt = |(irq_stat & irq_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      irq_en    <= '0;
      extra     <= '0;
      stat_halt <= 1'b0;
      stat_cond <= 1'b0;
      stat_ovf  <= 1'b0;
      halt_r    <= 1'b0;
      cond_r    <= 1'b0;
      rd_r      <= 1'b0;
    end else begin
      if (wr_ctrl)  ctrl   <= data_in[2:0];
      if (wr_en)    irq_en <= data_in[3:0];
      if (wr_extra) extra  <= data_in[EXTRA_W-1:0];
      halt_r <= prism_halt;
      cond_r <= prism_cond;
      rd_r   <= rd_act;
      // A new event in the same cycle as its W1C keeps the bit set.
      stat_halt <= (stat_halt & ~(wr_stat & data_in[0])) | halt_rise;
      stat_cond <= (stat_cond & ~(wr_stat & data_in[1])) | cond_rise;
      stat_ovf  <= (stat_ovf  & ~(wr_stat & data_in[3])) | ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts        <= '0;
      out_prev  <= '0;
      base_pend <= 1'b0;
    end else begin
      out_prev <= prism_out;
      if (cap_rise)     ts <= '0;
      else if (ctrl[2]) ts <= ts + 1'b1;
      if (cap_rise)      base_pend <= 1'b1;
      else if (push_req) base_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {ts, prism_out};
  end

  always_comb begin
    fifo_word              = '0;
    fifo_word[ENT_W-1:0]   = mem[rd_ptr];
    fifo_word[31]          = 1'b1;
    data_out               = '0;
    if (!is_local) begin
      data_out = prism_rdata;
    end else begin
      case (address)
        A_CTRL:  data_out[2:0] = ctrl;
        A_STAT:  data_out[3:0] = irq_stat;
        A_EN:    data_out[3:0] = irq_en;
        A_EXTRA: data_out[EXTRA_W-1:0] = extra;
        A_FDATA: if (!empty) data_out = fifo_word;
        A_FSTAT: begin
          data_out[DEPTH_LOG2:0] = count;
          data_out[8]            = full;
          data_out[9]            = empty;
          data_out[31]           = stat_ovf;
        end
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tqvp_prism_host_if.sv
// Directed bench for tqvp_prism_host_if with a queue scoreboard for FIFO contents.
module tb_tqvp_prism_host_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic        prism_reset;
  logic        prism_enable;
  logic        prism_dbg_wr;
  logic [31:0] prism_rdata;
  logic        prism_halt;
  logic        prism_cond;
  logic [12:0] prism_out;
  logic [8:0]  extra_in;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  tqvp_prism_host_if dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .user_interrupt(user_interrupt),
    .prism_reset(prism_reset), .prism_enable(prism_enable),
    .prism_dbg_wr(prism_dbg_wr), .prism_rdata(prism_rdata),
    .prism_halt(prism_halt), .prism_cond(prism_cond),
    .prism_out(prism_out), .extra_in(extra_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address = a;
    data_in = d;
    data_write_n = sz;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic rd_reg(input logic [5:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  function automatic logic [31:0] ent(input int t, input int o);
    logic [31:0] w;
    w = 32'h8000_0000;
    w[28:13] = t[15:0];
    w[12:0]  = o[12:0];
    return w;
  endfunction

  // Reads FIFO_DATA once and compares against the scoreboard head (0 when empty).
  task automatic rd_pop(input string tag);
    logic [31:0] e;
    address = 6'h30;
    data_read_n = 2'b00;
    #1;
    e = (exp_q.size() == 0) ? 32'h0 : exp_q.pop_front();
    chk(tag, data_out, e);
    tick();
    data_read_n = 2'b11;
    tick();
  endtask

  task automatic push_exp(input int t, input int o);
    if (exp_q.size() < 8) exp_q.push_back(ent(t, o));
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    address = 6'h0;
    data_in = 32'h0;
    data_write_n = 2'b11;
    data_read_n = 2'b11;
    prism_rdata = 32'h0;
    prism_halt = 1'b0;
    prism_cond = 1'b0;
    prism_out = 13'h0;
    tick();
    tick();
    rst = 1'b0;

    rd_reg(6'h34, v);
    chk("reset_fstat", v, 32'h200);
    chk("reset_irq", {31'h0, user_interrupt}, 32'h0);
    chk("reset_extra", {23'h0, extra_in}, 32'h0);
    chk("data_ready", {31'h0, data_ready}, 32'h1);

    wr(6'h2C, 32'h1A5, 2'b10);
    chk("extra_wr32", {23'h0, extra_in}, 32'h1A5);
    wr(6'h2C, 32'hFF, 2'b01);
    chk("extra_wr16_ignored", {23'h0, extra_in}, 32'h1A5);
    wr(6'h2C, 32'h3, 2'b00);
    chk("extra_wr8_ignored", {23'h0, extra_in}, 32'h1A5);
    rd_reg(6'h2C, v);
    chk("extra_readback", v, 32'h1A5);

    wr(6'h28, 32'h1, 2'b10);
    prism_halt = 1'b1;
    #1;
    chk("irq_before_rise", {31'h0, user_interrupt}, 32'h0);
    tick();
    chk("irq_after_rise", {31'h0, user_interrupt}, 32'h1);
    rd_reg(6'h24, v);
    chk("stat_halt_set", v, 32'h1);
    tick();
    tick();
    prism_halt = 1'b0;
    tick();
    wr(6'h24, 32'h1, 2'b10);
    chk("irq_w1c_clear", {31'h0, user_interrupt}, 32'h0);
    prism_halt = 1'b1;
    wr(6'h24, 32'h1, 2'b10);
    rd_reg(6'h24, v);
    chk("w1c_vs_rise", v, 32'h1);
    prism_halt = 1'b0;
    tick();
    wr(6'h24, 32'h1, 2'b10);
    prism_cond = 1'b1;
    tick();
    prism_cond = 1'b0;
    rd_reg(6'h24, v);
    chk("stat_cond_set", v, 32'h2);
    chk("irq_cond_masked", {31'h0, user_interrupt}, 32'h0);
    wr(6'h24, 32'h2, 2'b10);

    wr(6'h20, 32'h5, 2'b10);
    push_exp(0, 0);
    chk("ctrl_enable", {30'h0, prism_reset, prism_enable}, 32'h1);
    for (int i = 0; i < 10; i++) tick();
    prism_out = 13'h3;
    push_exp(10, 3);
    tick();
    rd_reg(6'h34, v);
    chk("cap_count2", v, 32'h2);
    rd_pop("cap_pop0");
    rd_pop("cap_pop1");
    rd_pop("cap_pop_empty");
    rd_reg(6'h34, v);
    chk("cap_drained", v, 32'h200);

    wr(6'h28, 32'h4, 2'b10);
    wr(6'h20, 32'h1, 2'b10);
    wr(6'h20, 32'h5, 2'b10);
    push_exp(0, 3);
    tick();
    for (int i = 0; i < 9; i++) begin
      prism_out = 13'(100 + i);
      push_exp(1 + i, 100 + i);
      tick();
    end
    rd_reg(6'h34, v);
    chk("ovf_fstat", v, 32'h8000_0108);
    rd_reg(6'h24, v);
    chk("ovf_stat", v, 32'hC);
    chk("irq_level", {31'h0, user_interrupt}, 32'h1);
    wr(6'h24, 32'h8, 2'b10);
    rd_reg(6'h24, v);
    chk("ovf_w1c", v, 32'h4);
    prism_out = 13'd200;
    rd_pop("full_pop_push");
    exp_q.push_back(ent(11, 200));
    rd_reg(6'h34, v);
    chk("full_pop_push_count", v, 32'h108);
    for (int i = 0; i < 8; i++) rd_pop($sformatf("drain%0d", i));
    rd_pop("drain_empty");

    address = 6'h04;
    data_in = 32'hDEAD;
    data_write_n = 2'b10;
    #1;
    chk("dbg_wr_high", {31'h0, prism_dbg_wr}, 32'h1);
    tick();
    data_write_n = 2'b11;
    #1;
    chk("dbg_wr_low", {31'h0, prism_dbg_wr}, 32'h0);
    prism_rdata = 32'h1234_5678;
    rd_reg(6'h04, v);
    chk("dbg_read", v, 32'h1234_5678);
    address = 6'h24;
    data_in = 32'h0;
    data_write_n = 2'b10;
    #1;
    chk("dbg_wr_local", {31'h0, prism_dbg_wr}, 32'h0);
    tick();
    data_write_n = 2'b11;

    prism_out = 13'h7;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    rd_reg(6'h34, v);
    chk("midrst_fstat", v, 32'h200);
    chk("midrst_ctrl", {29'h0, prism_enable, prism_reset, user_interrupt}, 32'h0);
    chk("midrst_extra", {23'h0, extra_in}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
